mix_columns_engine: RTL

//  Sequential, parametrised MixColumns/InvMixColumns engine for the AES round datapath.
//  - Takes a full NB-column state over a valid/ready handshake.
//  - Processes COLS_PER_CYCLE columns per clock and returns the transformed state

---
 rtl/mix_columns_engine_if.sv | 31 +++
 rtl/mix_columns_engine.sv | 136 +++++++++++++
 2 files changed

// File: rtl/mix_columns_engine_if.sv
// ---------------------------------------------------------------------------
// mix_columns_engine_if
//   Bundles the two valid/ready handshakes of the MixColumns engine.
//   Input side : in_valid, in_ready, in_state, in_inv
//   Output side: out_valid, out_ready, out_state
//   Status     : busy
//   modport master : the block feeding states and consuming results
//   modport slave  : the engine itself
// ---------------------------------------------------------------------------
interface mix_columns_if #(
    parameter int NB = 4
);
    logic              in_valid;
    logic              in_ready;
    logic [32*NB-1:0]  in_state;
    logic              in_inv;
    logic              out_valid;
    logic              out_ready;
    logic [32*NB-1:0]  out_state;
    logic              busy;

    modport master (
        output in_valid, in_state, in_inv, out_ready,
        input  in_ready, out_valid, out_state, busy
    );

    modport slave (
        input  in_valid, in_state, in_inv, out_ready,
        output in_ready, out_valid, out_state, busy
    );
endinterface

// File: rtl/mix_columns_engine.sv
// ---------------------------------------------------------------------------
// mix_columns_engine
//   Sequential AES MixColumns / InvMixColumns engine. A full NB-column state
//   is accepted, COLS_PER_CYCLE columns are transformed per clock, and the
//   result is held until the downstream side takes it.
//   Ports:
//     clk  : clock, rising edge
//     rst  : synchronous reset, active-high
//     bus  : mix_columns_if.slave (in_* request, out_* response, busy)
//   Column c of a state lives at bits [32*(NB-c)-1 -: 32], row 0 in the MSB.
// ---------------------------------------------------------------------------
module mix_columns_engine #(
    parameter int NB             = 4,
    parameter int COLS_PER_CYCLE = 1,
    parameter int INVERSE_EN     = 1
) (
    input  logic         clk,
    input  logic         rst,
    mix_columns_if.slave bus
);
    localparam int CPC     = COLS_PER_CYCLE;
    localparam int NGROUPS = NB / CPC;
    localparam int CNT_W   = (NGROUPS > 1) ? $clog2(NGROUPS) : 1;
    localparam int SW      = $clog2(32 * NB);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NGROUPS - 1);
    localparam logic INV_OK = (INVERSE_EN != 0);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    if ((CPC < 1) || ((NB % CPC) != 0)) begin : g_bad_cpc
        $error("mix_columns_engine: COLS_PER_CYCLE (%0d) must divide NB (%0d)", CPC, NB);
    end

    logic [1:0]        fsm;
    logic [CNT_W-1:0]  cnt;
    logic              mode_p0;
    logic [32*NB-1:0]  state_p0;
    logic [32*NB-1:0]  out_state_p1;
    logic [SW-1:0]     col_base [CPC];
    logic [31:0]       col_res  [CPC];

    // GF(2^8) doubling modulo x^8+x^4+x^3+x+1
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
    endfunction

    // One column through the forward (02 03 01 01) or inverse (0E 0B 0D 09)
    // circulant matrix; every product is an xtime/XOR chain.
    function automatic logic [31:0] mix_col(input logic [31:0] col, input logic inv);
        logic [7:0] a  [4];
        logic [7:0] x2 [4];
        logic [7:0] x4 [4];
        logic [7:0] x8 [4];
        logic [7:0] r  [4];
        for (int i = 0; i < 4; i++) begin
            a[i]  = col[31-8*i -: 8];
            x2[i] = xtime(a[i]);
            x4[i] = xtime(x2[i]);
            x8[i] = xtime(x4[i]);
        end
        for (int i = 0; i < 4; i++) begin
            if (inv) begin
                r[i] = (x8[i] ^ x4[i] ^ x2[i])                      // 0E
                     ^ (x8[(i+1)%4] ^ x2[(i+1)%4] ^ a[(i+1)%4])    // 0B
                     ^ (x8[(i+2)%4] ^ x4[(i+2)%4] ^ a[(i+2)%4])    // 0D
                     ^ (x8[(i+3)%4] ^ a[(i+3)%4]);                 // 09
            end else begin
                r[i] = x2[i]
                     ^ (x2[(i+1)%4] ^ a[(i+1)%4])
                     ^ a[(i+2)%4]
                     ^ a[(i+3)%4];
            end
        end
        return {r[0], r[1], r[2], r[3]};
    endfunction

    // Stage p0 -> p1: transform the column group selected by cnt
    always_comb begin
        for (int g = 0; g < CPC; g++) begin
            col_base[g] = SW'(32 * (NB - 1 - (int'(cnt) * CPC + g)));
            col_res[g]  = mix_col(state_p0[col_base[g] +: 32], mode_p0);
        end
    end

    // Stage p0: captured input state (pure data, loaded on acceptance)
    always_ff @(posedge clk) begin
        if (bus.in_valid && bus.in_ready) begin
            state_p0 <= bus.in_state;
        end
    end

    // Stage p1: control FSM and result register
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm          <= ST_IDLE;
            cnt          <= '0;
            mode_p0      <= 1'b0;
            out_state_p1 <= '0;
        end else begin
            case (fsm)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        mode_p0 <= bus.in_inv & INV_OK;
                        cnt     <= '0;
                        fsm     <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    for (int g = 0; g < CPC; g++) begin
                        out_state_p1[col_base[g] +: 32] <= col_res[g];
                    end
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST_CNT) begin
                        fsm <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        fsm <= ST_IDLE;
                    end
                end
                default: fsm <= ST_IDLE;
            endcase
        end
    end

    // in_ready is forced low while rst is asserted so nothing is accepted
    // on the reset edge.
    assign bus.in_ready  = (fsm == ST_IDLE) && !rst;
    assign bus.out_valid = (fsm == ST_DONE);
    assign bus.busy      = (fsm == ST_CALC) || (fsm == ST_DONE);
    assign bus.out_state = out_state_p1;

endmodule
